// File: rtl/data_mem_lsu.sv
// Byte-addressable RV32 data memory for the MEM stage: sized loads/stores over a
// valid/ready request/response handshake, registered read, misalign/range faults.
module data_mem_lsu #(
  parameter int unsigned       DEPTH     = 1024,
  parameter int unsigned       ADDR_W    = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err,
  output logic              rsp_fault
);

  localparam int unsigned       IDX_W   = $clog2(DEPTH);
  localparam logic [ADDR_W-3:0] DEPTH_W = (ADDR_W-2)'(DEPTH);

  logic [31:0]       r_mem [DEPTH];
  logic              r_rsp_valid;
  logic [31:0]       r_rsp_rdata;
  logic              r_rsp_err;
  logic              r_rsp_fault;

  logic              w_accept;
  logic [ADDR_W-1:0] w_off;
  logic [ADDR_W-3:0] w_word;
  logic [IDX_W-1:0]  w_idx;
  logic [1:0]        w_lane;
  logic              w_fault;
  logic              w_err;
  logic              w_ok;
  logic [3:0]        w_be;
  logic [31:0]       w_wdata;
  logic [31:0]       w_rword;
  logic [31:0]       w_shift;
  logic [31:0]       w_load;

  assign req_ready = reset & (~r_rsp_valid | rsp_ready);
  assign w_accept  = req_valid & req_ready;

  assign w_off   = req_addr - BASE_ADDR;
  assign w_word  = w_off[ADDR_W-1:2];
  assign w_idx   = w_off[IDX_W+1:2];
  assign w_lane  = w_off[1:0];
  assign w_fault = (req_addr < BASE_ADDR) | (w_word >= DEPTH_W);
  assign w_ok    = ~w_err & ~w_fault;

  assign w_rword = r_mem[w_idx];
  assign w_shift = w_rword >> {w_lane, 3'b000};

  // Alignment check, lane enables, replicated store data and load extension.
  always_comb begin
    w_err   = 1'b0;
    w_be    = 4'b0000;
    w_wdata = req_wdata;
    w_load  = w_rword;
    case (req_size)
      2'b00: begin
        w_be    = 4'b0001 << w_lane;
        w_wdata = {4{req_wdata[7:0]}};
        w_load  = req_unsigned ? {24'h00_0000, w_shift[7:0]}
                               : {{24{w_shift[7]}}, w_shift[7:0]};
      end
      2'b01: begin
        w_err   = w_lane[0];
        w_be    = 4'b0011 << w_lane;
        w_wdata = {2{req_wdata[15:0]}};
        w_load  = req_unsigned ? {16'h0000, w_shift[15:0]}
                               : {{16{w_shift[15]}}, w_shift[15:0]};
      end
      2'b10: begin
        w_err = (w_lane != 2'b00);
        w_be  = 4'b1111;
      end
      default: begin
        w_err = 1'b1;
      end
    endcase
  end

  // Byte-lane store on the accept edge; contents survive reset.
  always_ff @(posedge clk) begin
    if (w_accept & req_we & w_ok) begin
      for (int b = 0; b < 4; b++) begin
        if (w_be[b]) r_mem[w_idx][8*b +: 8] <= w_wdata[8*b +: 8];
      end
    end
  end

  // Response register: load a new response on accept, drop it when consumed.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= 32'h0000_0000;
      r_rsp_err   <= 1'b0;
      r_rsp_fault <= 1'b0;
    end else if (w_accept) begin
      r_rsp_valid <= 1'b1;
      r_rsp_rdata <= (~req_we & w_ok) ? w_load : 32'h0000_0000;
      r_rsp_err   <= w_err;
      r_rsp_fault <= w_fault;
    end else if (rsp_ready) begin
      r_rsp_valid <= 1'b0;
    end
  end

  assign rsp_valid = r_rsp_valid;
  assign rsp_rdata = r_rsp_rdata;
  assign rsp_err   = r_rsp_err;
  assign rsp_fault = r_rsp_fault;

endmodule

// File: tb/tb_data_mem_lsu.sv
// Self-checking bench for data_mem_lsu: byte-array reference model with a per-cycle
// compare process, directed literal checks and a randomized traffic phase.
module tb_data_mem_lsu;
  localparam int          DEPTH = 1024;
  localparam logic [31:0] BASE  = 32'h0000_0000;

  logic        clk, reset, req_valid, req_ready, req_we, req_unsigned;
  logic [31:0] req_addr, req_wdata, rsp_rdata;
  logic [1:0]  req_size;
  logic        rsp_valid, rsp_ready, rsp_err, rsp_fault;

  data_mem_lsu #(.DEPTH(DEPTH), .ADDR_W(32), .BASE_ADDR(BASE)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_addr(req_addr), .req_size(req_size),
    .req_unsigned(req_unsigned), .req_wdata(req_wdata), .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .rsp_fault(rsp_fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [7:0]  mem_m [0:4*DEPTH-1];
  logic        exp_valid = 1'b0;
  logic [31:0] exp_rdata = 32'h0;
  logic        exp_err = 1'b0, exp_fault = 1'b0;
  int          checks = 0, errors = 0;
  bit          chk_en = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Reference model: advance one clock, computing the next response from the rules.
  task automatic cycle(output bit acc);
    longint      la, off;
    bit          f, e;
    int          n;
    logic [31:0] v;
    logic        nv, ne, nf;
    logic [31:0] nr;
    acc = reset && req_valid && (!exp_valid || rsp_ready);
    nv = exp_valid; nr = exp_rdata; ne = exp_err; nf = exp_fault;
    if (!reset) begin
      nv = 1'b0; nr = 32'h0; ne = 1'b0; nf = 1'b0;
    end else if (acc) begin
      la  = longint'(req_addr);
      off = la - longint'(BASE);
      f   = (la < longint'(BASE)) || (off >= 4 * DEPTH);
      e   = (req_size == 2'd3) || (req_size == 2'd1 && la % 2 != 0) ||
            (req_size == 2'd2 && la % 4 != 0);
      nv = 1'b1; ne = e; nf = f; nr = 32'h0;
      if (!e && !f) begin
        n = 1 << req_size;
        if (req_we) begin
          for (int k = 0; k < n; k++) mem_m[int'(off) + k] = req_wdata[8*k +: 8];
        end else begin
          v = 32'h0;
          for (int k = 0; k < n; k++) v[8*k +: 8] = mem_m[int'(off) + k];
          if (!req_unsigned && n < 4 && v[8*n-1])
            for (int k = n; k < 4; k++) v[8*k +: 8] = 8'hFF;
          nr = v;
        end
      end
    end else if (rsp_ready) begin
      nv = 1'b0;
    end
    @(posedge clk);
    exp_valid = nv; exp_rdata = nr; exp_err = ne; exp_fault = nf;
    #1;
  endtask

  // Per-cycle comparison of DUT outputs against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("req_ready", {31'h0, req_ready}, {31'h0, reset && (!exp_valid || rsp_ready)});
      chk("rsp_valid", {31'h0, rsp_valid}, {31'h0, exp_valid});
      if (exp_valid) begin
        chk("rsp_rdata", rsp_rdata, exp_rdata);
        chk("rsp_flags", {30'h0, rsp_err, rsp_fault}, {30'h0, exp_err, exp_fault});
      end
    end
  end

  task automatic xact(input bit we, input logic [31:0] a, input logic [1:0] sz,
                      input bit u, input logic [31:0] wd);
    bit acc = 1'b0;
    req_valid = 1'b1; req_we = we; req_addr = a; req_size = sz;
    req_unsigned = u; req_wdata = wd; rsp_ready = 1'b1;
    for (int i = 0; i < 8 && !acc; i++) cycle(acc);
    req_valid = 1'b0;
    checks++;
    if (!acc) begin
      errors++;
      $display("FAIL accept_timeout: got no accept expected accept at %h", a);
    end
  endtask

  task automatic expect_rsp(input string nm, input logic [31:0] rd, input bit e, input bit f);
    chk({nm, " valid"}, {31'h0, rsp_valid}, 32'h1);
    chk({nm, " dut"}, rsp_rdata, rd);
    chk({nm, " model"}, exp_rdata, rd);
    chk({nm, " flags"}, {30'h0, rsp_err, rsp_fault}, {30'h0, e, f});
  endtask

  initial begin
    bit acc;
    int cnt;
    int r;
    reset = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_addr = 32'h0;
    req_size = 2'b10; req_unsigned = 1'b0; req_wdata = 32'h0; rsp_ready = 1'b0;
    cycle(acc); cycle(acc);
    chk_en = 1'b1;
    chk("reset valid", {31'h0, rsp_valid}, 32'h0);
    chk("reset rdata", rsp_rdata, 32'h0);
    chk("reset ready", {31'h0, req_ready}, 32'h0);
    reset = 1'b1;
    for (int i = 0; i < DEPTH; i++) xact(1'b1, 32'(4 * i), 2'b10, 1'b0, 32'h0);

    xact(1'b1, 32'h10, 2'b10, 1'b0, 32'hDEAD_BEEF);
    xact(1'b0, 32'h10, 2'b10, 1'b0, 32'h0);
    expect_rsp("lw_deadbeef", 32'hDEAD_BEEF, 1'b0, 1'b0);

    xact(1'b1, 32'h10, 2'b10, 1'b0, 32'h1122_3344);
    xact(1'b1, 32'h13, 2'b00, 1'b0, 32'h0000_0080);
    xact(1'b0, 32'h13, 2'b00, 1'b0, 32'h0);
    expect_rsp("lb_13", 32'hFFFF_FF80, 1'b0, 1'b0);
    xact(1'b0, 32'h13, 2'b00, 1'b1, 32'h0);
    expect_rsp("lbu_13", 32'h0000_0080, 1'b0, 1'b0);
    xact(1'b0, 32'h10, 2'b10, 1'b0, 32'h0);
    expect_rsp("lw_merged", 32'h8022_3344, 1'b0, 1'b0);

    xact(1'b1, 32'h22, 2'b01, 1'b0, 32'h0000_A5A5);
    xact(1'b0, 32'h22, 2'b01, 1'b0, 32'h0);
    expect_rsp("lh_22", 32'hFFFF_A5A5, 1'b0, 1'b0);
    xact(1'b0, 32'h20, 2'b01, 1'b1, 32'h0);
    expect_rsp("lhu_20", 32'h0000_0000, 1'b0, 1'b0);

    xact(1'b0, 32'h21, 2'b01, 1'b0, 32'h0);
    expect_rsp("lh_misalign", 32'h0, 1'b1, 1'b0);
    xact(1'b1, 32'h12, 2'b10, 1'b0, 32'hFFFF_FFFF);
    expect_rsp("sw_misalign", 32'h0, 1'b1, 1'b0);
    xact(1'b0, 32'h10, 2'b11, 1'b0, 32'h0);
    expect_rsp("size_illegal", 32'h0, 1'b1, 1'b0);
    xact(1'b0, 32'h10, 2'b10, 1'b0, 32'h0);
    expect_rsp("lw_unchanged", 32'h8022_3344, 1'b0, 1'b0);

    xact(1'b1, 32'h1000, 2'b10, 1'b0, 32'hCAFE_F00D);
    expect_rsp("sw_oor", 32'h0, 1'b0, 1'b1);
    xact(1'b0, 32'h1001, 2'b01, 1'b0, 32'h0);
    expect_rsp("lh_err_fault", 32'h0, 1'b1, 1'b1);
    xact(1'b1, 32'hFFC, 2'b10, 1'b0, 32'h1234_5678);
    xact(1'b0, 32'hFFC, 2'b10, 1'b0, 32'h0);
    expect_rsp("lw_top", 32'h1234_5678, 1'b0, 1'b0);
    xact(1'b0, 32'h0, 2'b10, 1'b0, 32'h0);
    expect_rsp("lw_wrap_check", 32'h0, 1'b0, 1'b0);

    // Backpressure: response held, no new accept for three cycles.
    xact(1'b0, 32'h10, 2'b10, 1'b0, 32'h0);
    rsp_ready = 1'b0; req_valid = 1'b1; req_addr = 32'h20; req_size = 2'b10;
    for (int i = 0; i < 3; i++) begin
      cycle(acc);
      chk("stall ready", {31'h0, req_ready}, 32'h0);
      chk("stall data", rsp_rdata, 32'h8022_3344);
    end
    rsp_ready = 1'b1; cnt = 0;
    for (int i = 0; i < 4; i++) begin
      req_addr = 32'(4 * i + 16);
      cycle(acc);
      if (acc) cnt++;
    end
    chk("throughput", 32'(cnt), 32'd4);

    // Reset while a response is stalled.
    rsp_ready = 1'b0; req_addr = 32'h10;
    cycle(acc); cycle(acc);
    reset = 1'b0;
    cycle(acc);
    chk("rst valid", {31'h0, rsp_valid}, 32'h0);
    chk("rst ready", {31'h0, req_ready}, 32'h0);
    cycle(acc);
    reset = 1'b1; req_valid = 1'b0; rsp_ready = 1'b1;
    cycle(acc);
    xact(1'b0, 32'hFFC, 2'b10, 1'b0, 32'h0);
    expect_rsp("rst keeps mem", 32'h1234_5678, 1'b0, 1'b0);

    // Randomized traffic checked every cycle by the compare process.
    for (int i = 0; i < 4000; i++) begin
      reset        = ($urandom_range(0, 149) != 0);
      req_valid    = $urandom_range(0, 3) != 0;
      rsp_ready    = $urandom_range(0, 3) != 0;
      req_we       = $urandom_range(0, 1) != 0;
      req_unsigned = $urandom_range(0, 1) != 0;
      req_size     = 2'($urandom_range(0, 3));
      req_wdata    = $urandom;
      r = $urandom_range(0, 9);
      if (r < 8)       req_addr = 32'($urandom_range(0, 4 * DEPTH - 1));
      else if (r == 8) req_addr = 32'(4 * DEPTH + $urandom_range(0, 63));
      else             req_addr = $urandom;
      cycle(acc);
    end

    chk_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
